// File: rtl/wb_port_responder_if.sv
// Wishbone slave bus bundle for wb_port_responder.
// The master drives cyc/stb/we/sel/adr/dat_i; the responder returns ack and dat_o.
interface wb_port_responder_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_port_responder.sv
// Wishbone register block: pad check bits, free-running counter with compare
// interrupt, and a small 16-bit mailbox FIFO with sticky error flags.
//
// Handshake: an access is taken when cyc & stb & address hit while the FSM is
// IDLE and the previous access has been released; ack follows for exactly one
// cycle. A master that keeps cyc/stb high after ack is not served again until
// it drops them for at least one cycle.
module wb_port_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 resetb,
  wb_port_responder_if.slave   wbs,
  output logic [15:0]          io_out,
  output logic [15:0]          io_oeb,
  output logic                 irq_o,
  output logic                 dbg_state
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = AW + 1;

  localparam logic [5:0] IDX_CHECK   = 6'h00;
  localparam logic [5:0] IDX_CTRL    = 6'h01;
  localparam logic [5:0] IDX_COUNT   = 6'h02;
  localparam logic [5:0] IDX_COMPARE = 6'h03;
  localparam logic [5:0] IDX_STATUS  = 6'h04;
  localparam logic [5:0] IDX_FIFO    = 6'h05;

  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                hold_q;
  logic [15:0]         check_q;
  logic [2:0]          ctrl_q;
  logic [31:0]         count_q;
  logic [31:0]         compare_q;
  logic                match_q, ovf_q, unf_q;
  logic                irq_q;
  logic [31:0]         dat_o_q;
  logic [15:0]         fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]    occ_q;

  logic                selected, accept, wr_acc, rd_acc;
  logic [5:0]          idx;
  logic                fifo_empty, fifo_full;
  logic [31:0]         rd_data;
  logic [31:0]         check_nx, ctrl_nx, count_nx, compare_nx, fifo_din;
  logic [4:0]          clr_bits;
  logic                push, pop, do_push, do_pop;
  logic                match_set, ovf_set, unf_set;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  assign selected = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                    (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign idx      = wbs.wbs_adr_i[7:2];
  assign accept   = (state_q == S_IDLE) & selected & ~hold_q;
  assign wr_acc   = accept &  wbs.wbs_we_i;
  assign rd_acc   = accept & ~wbs.wbs_we_i;

  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == OCC_W'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Remember a still-held access so it is not executed a second time.
      if (state_q == S_ACK) hold_q <= selected;
      else if (!selected)   hold_q <= 1'b0;
    end
  end

  // Read data is taken from pre-access register state.
  always_comb begin
    rd_data = 32'h0;
    case (idx)
      IDX_CHECK:   rd_data = {16'h0, check_q};
      IDX_CTRL:    rd_data = {29'h0, ctrl_q};
      IDX_COUNT:   rd_data = count_q;
      IDX_COMPARE: rd_data = compare_q;
      IDX_STATUS:  rd_data = {27'h0, unf_q, ovf_q, fifo_full, fifo_empty, match_q};
      IDX_FIFO:    rd_data = fifo_empty ? 32'h0 : {16'h0, fifo_mem[rd_ptr_q]};
      default:     rd_data = 32'h0;
    endcase
  end

  always_comb begin
    check_nx   = merge_bytes({16'h0, check_q}, wbs.wbs_dat_i, wbs.wbs_sel_i);
    ctrl_nx    = merge_bytes({29'h0, ctrl_q}, wbs.wbs_dat_i, wbs.wbs_sel_i);
    count_nx   = merge_bytes(count_q, wbs.wbs_dat_i, wbs.wbs_sel_i);
    compare_nx = merge_bytes(compare_q, wbs.wbs_dat_i, wbs.wbs_sel_i);
    fifo_din   = merge_bytes(32'h0, wbs.wbs_dat_i, wbs.wbs_sel_i);
    clr_bits   = 5'h0;
    if (wr_acc && idx == IDX_STATUS && wbs.wbs_sel_i[0]) clr_bits = wbs.wbs_dat_i[4:0];
  end

  assign push      = wr_acc & (idx == IDX_FIFO);
  assign pop       = rd_acc & (idx == IDX_FIFO);
  assign do_push   = push & ~fifo_full;
  assign do_pop    = pop & ~fifo_empty;
  assign ovf_set   = push & fifo_full;
  assign unf_set   = pop & fifo_empty;
  assign match_set = ctrl_q[0] & (count_q == compare_q);

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      check_q   <= 16'h0;
      ctrl_q    <= 3'h0;
      count_q   <= 32'h0;
      compare_q <= 32'h0;
      match_q   <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      irq_q     <= 1'b0;
      dat_o_q   <= 32'h0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
    end else begin
      if (accept) dat_o_q <= rd_data;
      if (wr_acc && idx == IDX_CHECK)   check_q   <= check_nx[15:0];
      if (wr_acc && idx == IDX_CTRL)    ctrl_q    <= ctrl_nx[2:0];
      if (wr_acc && idx == IDX_COMPARE) compare_q <= compare_nx;
      // A bus write to COUNT takes priority over that cycle's increment.
      if (wr_acc && idx == IDX_COUNT && wbs.wbs_sel_i != 4'h0) count_q <= count_nx;
      else if (ctrl_q[0])                                      count_q <= count_q + 32'd1;
      match_q <= match_set | (match_q & ~clr_bits[0]);
      ovf_q   <= ovf_set   | (ovf_q   & ~clr_bits[3]);
      unf_q   <= unf_set   | (unf_q   & ~clr_bits[4]);
      irq_q   <= match_q & ctrl_q[2];
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push)     occ_q <= occ_q + OCC_W'(1);
      else if (do_pop) occ_q <= occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (do_push) fifo_mem[wr_ptr_q] <= fifo_din[15:0];
  end

  assign wbs.wbs_ack_o = (state_q == S_ACK);
  assign wbs.wbs_dat_o = dat_o_q;
  assign io_out        = check_q;
  assign io_oeb        = ctrl_q[1] ? 16'h0000 : 16'hFFFF;
  assign irq_o         = irq_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_wb_port_responder.sv
// Directed bench for wb_port_responder: registers, counter/compare irq, FIFO,
// held-strobe handshake, address miss and reset during an access.
module tb_wb_port_responder;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        resetb;
  logic [15:0] io_out, io_oeb;
  logic        irq_o;
  logic        dbg_state;
  int          n_assert;
  int          n_fail;
  int          cycle_cnt;
  int          ack_cyc;
  int          waited;
  int          acks;
  logic [31:0] rd, r1, r2, exp_v;
  int          c1, c2, cc;

  wb_port_responder_if bus ();

  wb_port_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
    .wb_clk_i  (clk),
    .resetb    (resetb),
    .wbs       (bus.slave),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq_o     (irq_o),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
  endtask

  task automatic bus_drive(input logic we, input logic [31:0] adr,
                           input logic [31:0] wd, input logic [3:0] sel);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wd;
  endtask

  // One classic-cycle access; strobe is dropped as soon as ack is seen.
  task automatic xfer(input logic we, input logic [5:0] idx, input logic [31:0] wd,
                      input logic [3:0] sel, output logic [31:0] rdata);
    logic got;
    got = 1'b0;
    rdata = 32'h0;
    waited = 0;
    @(posedge clk); #1;
    bus_drive(we, BASE + {24'h0, idx, 2'b00}, wd, sel);
    for (int i = 0; i < 16 && !got; i++) begin
      @(posedge clk); #1;
      waited++;
      if (bus.wbs_ack_o) begin
        got = 1'b1;
        rdata = bus.wbs_dat_o;
        ack_cyc = cycle_cnt;
      end
    end
    bus_idle();
    check("ack_seen", {31'h0, got}, 32'h1);
  endtask

  task automatic wr(input logic [5:0] idx, input logic [31:0] wd);
    logic [31:0] dummy;
    xfer(1'b1, idx, wd, 4'hF, dummy);
  endtask

  task automatic rd_reg(input logic [5:0] idx, output logic [31:0] v);
    xfer(1'b0, idx, 32'h0, 4'hF, v);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    bus_idle();
    resetb = 1'b1;
    #1 resetb = 1'b0;
    #1;
    check("rst_ack",    {31'h0, bus.wbs_ack_o}, 32'h0);
    check("rst_dat_o",  bus.wbs_dat_o, 32'h0);
    check("rst_io_out", {16'h0, io_out}, 32'h0);
    check("rst_io_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
    check("rst_irq",    {31'h0, irq_o}, 32'h0);
    check("rst_state",  {31'h0, dbg_state}, 32'h0);
    repeat (2) @(posedge clk);
    #2 resetb = 1'b1;

    // pad check bits and output enables
    wr(6'h00, 32'h0000_AB60);
    wr(6'h01, 32'h0000_0002);
    #1;
    check("io_out_ab60", {16'h0, io_out}, 32'h0000_AB60);
    check("io_oeb_on",   {16'h0, io_oeb}, 32'h0);
    wr(6'h00, 32'h0000_AB61);
    #1;
    check("io_out_ab61", {16'h0, io_out}, 32'h0000_AB61);
    rd_reg(6'h00, rd);
    check("rd_check", rd, 32'h0000_AB61);
    xfer(1'b1, 6'h00, 32'hFFFF_CD00, 4'b0010, rd);
    rd_reg(6'h00, rd);
    check("check_sel_byte1", rd, 32'h0000_CD61);
    rd_reg(6'h01, rd);
    check("rd_ctrl", rd, 32'h0000_0002);
    rd_reg(6'h3F, rd);
    check("rd_unmapped", rd, 32'h0);

    // counter runs one per cycle
    wr(6'h01, 32'h0000_0001);
    rd_reg(6'h02, r1); c1 = ack_cyc;
    rd_reg(6'h02, r2); c2 = ack_cyc;
    check("count_delta", r2 - r1, 32'(c2 - c1));

    // counter wrap
    wr(6'h01, 32'h0);
    wr(6'h02, 32'hFFFF_FFFE);
    rd_reg(6'h02, rd);
    check("count_loaded", rd, 32'hFFFF_FFFE);
    wr(6'h01, 32'h0000_0001); cc = ack_cyc;
    repeat (3) @(posedge clk);
    rd_reg(6'h02, rd);
    exp_v = 32'hFFFF_FFFE + 32'(ack_cyc - cc - 1);
    check("count_wrap_val", rd, exp_v);
    check("count_wrapped",  {31'h0, rd < 32'd16}, 32'h1);

    // compare match and interrupt
    wr(6'h01, 32'h0);
    wr(6'h02, 32'h0);
    wr(6'h03, 32'd20);
    wr(6'h01, 32'h0000_0005);
    repeat (30) @(posedge clk);
    #1;
    check("irq_set", {31'h0, irq_o}, 32'h1);
    rd_reg(6'h04, rd);
    check("status_match", rd, 32'h0000_0003);
    wr(6'h04, 32'h0000_0001);
    repeat (2) @(posedge clk);
    #1;
    check("irq_cleared", {31'h0, irq_o}, 32'h0);
    rd_reg(6'h04, rd);
    check("status_cleared", rd, 32'h0000_0002);
    wr(6'h01, 32'h0);

    // FIFO fill, overflow, drain, underflow
    for (int i = 1; i <= 5; i++) wr(6'h05, 32'(i));
    rd_reg(6'h04, rd);
    check("status_full_ovf", rd, 32'h0000_000C);
    for (int i = 1; i <= 4; i++) begin
      rd_reg(6'h05, rd);
      check("fifo_pop", rd, 32'(i));
    end
    rd_reg(6'h05, rd);
    check("fifo_pop_empty", rd, 32'h0);
    rd_reg(6'h04, rd);
    check("status_unf", rd, 32'h0000_001A);
    wr(6'h04, 32'h0000_0018);
    rd_reg(6'h04, rd);
    check("status_w1c", rd, 32'h0000_0002);

    // strobe held across four cycles gives one ack and one pop
    wr(6'h05, 32'h0000_0007);
    wr(6'h05, 32'h0000_0008);
    @(posedge clk); #1;
    bus_drive(1'b0, BASE + 32'h14, 32'h0, 4'hF);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) acks++;
    end
    bus_idle();
    check("held_one_ack", 32'(acks), 32'h1);
    rd_reg(6'h05, rd);
    check("held_one_pop", rd, 32'h0000_0008);

    // address outside the block
    @(posedge clk); #1;
    bus_drive(1'b0, 32'h3100_0000, 32'h0, 4'hF);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) acks++;
    end
    bus_idle();
    check("miss_no_ack", 32'(acks), 32'h0);

    // reset in the middle of an access
    wr(6'h00, 32'h0000_1234);
    wr(6'h01, 32'h0000_0007);
    wr(6'h03, 32'h0000_0005);
    @(posedge clk); #1;
    bus_drive(1'b1, BASE + 32'h08, 32'hDEAD_BEEF, 4'hF);
    #2 resetb = 1'b0;
    #1;
    check("rst_mid_io_out", {16'h0, io_out}, 32'h0);
    check("rst_mid_io_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) acks++;
    end
    bus_idle();
    #1 resetb = 1'b1;
    @(posedge clk); #1;
    if (bus.wbs_ack_o) acks++;
    check("rst_mid_no_ack", 32'(acks), 32'h0);
    rd_reg(6'h00, rd);
    check("post_rst_first_accept", 32'(waited), 32'h1);
    check("post_rst_check", rd, 32'h0);
    rd_reg(6'h01, rd);
    check("post_rst_ctrl", rd, 32'h0);
    rd_reg(6'h02, rd);
    check("post_rst_count", rd, 32'h0);
    rd_reg(6'h03, rd);
    check("post_rst_compare", rd, 32'h0);
    rd_reg(6'h04, rd);
    check("post_rst_status", rd, 32'h0000_0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
